// File: rtl/reorder_buffer.sv
// Circular in-order commit buffer: allocates rename tags, captures two
// writeback buses, and retires from the head (reg write, store release, flush).
module reorder_buffer #(
    parameter int ROB_SIZE_BIT = 4
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    rdy_in,
    input  logic                    issue_valid,
    input  logic [4:0]              issue_rd,
    input  logic                    issue_is_br,
    input  logic                    issue_is_store,
    input  logic [31:0]             issue_pred_pc,
    output logic [ROB_SIZE_BIT-1:0] issue_tag,
    output logic                    rob_full,
    input  logic                    wb1_valid,
    input  logic [ROB_SIZE_BIT-1:0] wb1_tag,
    input  logic [31:0]             wb1_val,
    input  logic [31:0]             wb1_next_pc,
    input  logic                    wb2_valid,
    input  logic [ROB_SIZE_BIT-1:0] wb2_tag,
    input  logic [31:0]             wb2_val,
    input  logic [ROB_SIZE_BIT-1:0] qry1_tag,
    input  logic [ROB_SIZE_BIT-1:0] qry2_tag,
    output logic                    qry1_ready,
    output logic                    qry2_ready,
    output logic [31:0]             qry1_val,
    output logic [31:0]             qry2_val,
    output logic [4:0]              rob_set_idx,
    output logic [31:0]             rob_set_reg_val,
    output logic [ROB_SIZE_BIT-1:0] rob_set_recorder,
    output logic                    rob_clear,
    output logic [31:0]             clear_pc,
    output logic                    store_commit,
    output logic [ROB_SIZE_BIT-1:0] store_tag
);
    localparam int SIZE = 1 << ROB_SIZE_BIT;
    localparam int CW = ROB_SIZE_BIT + 1;
    typedef logic [ROB_SIZE_BIT-1:0] tag_t;

    tag_t            head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;
    logic [SIZE-1:0] busy_q, busy_d, ready_q, ready_d;
    logic [SIZE-1:0] is_br_q, is_br_d, is_st_q, is_st_d;
    logic [4:0]      rd_q [SIZE];
    logic [4:0]      rd_d [SIZE];
    logic [31:0]     val_q [SIZE];
    logic [31:0]     val_d [SIZE];
    logic [31:0]     npc_q [SIZE];
    logic [31:0]     npc_d [SIZE];
    logic [31:0]     pred_q [SIZE];
    logic [31:0]     pred_d [SIZE];
    logic            clear_pending_q, clear_pending_d;
    logic [4:0]      set_idx_q, set_idx_d;
    logic [31:0]     set_val_q, set_val_d;
    tag_t            set_rec_q, set_rec_d;
    logic            rob_clear_q, rob_clear_d;
    logic [31:0]     clear_pc_q, clear_pc_d;
    logic            st_commit_q, st_commit_d;
    tag_t            st_tag_q, st_tag_d;

    logic accept, commit, mispredict, wb_ok;

    assign rob_full = (count_q == CW'(SIZE)) | clear_pending_q | rob_clear_q;
    assign issue_tag = tail_q;
    assign accept = issue_valid & ~rob_full;
    // Commit only on a ready bit latched before this edge; no writeback bypass.
    assign commit = (count_q != '0) & ready_q[head_q];
    assign mispredict = commit & is_br_q[head_q] &
                        (npc_q[head_q] != pred_q[head_q]);
    assign wb_ok = ~clear_pending_q & ~rob_clear_q;

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        count_d = count_q + CW'(accept) - CW'(commit);
        busy_d = busy_q;
        ready_d = ready_q;
        is_br_d = is_br_q;
        is_st_d = is_st_q;
        rd_d = rd_q;
        val_d = val_q;
        npc_d = npc_q;
        pred_d = pred_q;
        clear_pending_d = 1'b0;
        set_idx_d = 5'd0;
        set_val_d = set_val_q;
        set_rec_d = set_rec_q;
        rob_clear_d = clear_pending_q;
        clear_pc_d = clear_pc_q;
        st_commit_d = 1'b0;
        st_tag_d = st_tag_q;

        if (wb1_valid && wb_ok && busy_q[wb1_tag]) begin
            ready_d[wb1_tag] = 1'b1;
            val_d[wb1_tag] = wb1_val;
            npc_d[wb1_tag] = wb1_next_pc;
        end
        if (wb2_valid && wb_ok && busy_q[wb2_tag]) begin
            ready_d[wb2_tag] = 1'b1;
            val_d[wb2_tag] = wb2_val;
        end

        if (accept) begin
            busy_d[tail_q] = 1'b1;
            ready_d[tail_q] = 1'b0;
            is_br_d[tail_q] = issue_is_br;
            is_st_d[tail_q] = issue_is_store;
            rd_d[tail_q] = issue_rd;
            pred_d[tail_q] = issue_pred_pc;
            tail_d = tail_q + 1'b1;
        end

        if (commit) begin
            busy_d[head_q] = 1'b0;
            ready_d[head_q] = 1'b0;
            head_d = head_q + 1'b1;
            set_idx_d = rd_q[head_q];
            set_val_d = val_q[head_q];
            set_rec_d = head_q;
            st_commit_d = is_st_q[head_q];
            st_tag_d = head_q;
        end

        // The register write above still lands; rob_clear follows one cycle later.
        if (mispredict) begin
            busy_d = '0;
            ready_d = '0;
            head_d = '0;
            tail_d = '0;
            count_d = '0;
            clear_pending_d = 1'b1;
            clear_pc_d = npc_q[head_q];
        end
    end

    always_comb begin
        qry1_ready = ready_q[qry1_tag];
        qry1_val = val_q[qry1_tag];
        if (wb2_valid && wb2_tag == qry1_tag) begin
            qry1_ready = 1'b1;
            qry1_val = wb2_val;
        end
        if (wb1_valid && wb1_tag == qry1_tag) begin
            qry1_ready = 1'b1;
            qry1_val = wb1_val;
        end
        qry2_ready = ready_q[qry2_tag];
        qry2_val = val_q[qry2_tag];
        if (wb2_valid && wb2_tag == qry2_tag) begin
            qry2_ready = 1'b1;
            qry2_val = wb2_val;
        end
        if (wb1_valid && wb1_tag == qry2_tag) begin
            qry2_ready = 1'b1;
            qry2_val = wb1_val;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            head_q <= '0;
            tail_q <= '0;
            count_q <= '0;
            busy_q <= '0;
            ready_q <= '0;
            is_br_q <= '0;
            is_st_q <= '0;
            for (int i = 0; i < SIZE; i++) begin
                rd_q[i] <= '0;
                val_q[i] <= '0;
                npc_q[i] <= '0;
                pred_q[i] <= '0;
            end
            clear_pending_q <= 1'b0;
            set_idx_q <= '0;
            set_val_q <= '0;
            set_rec_q <= '0;
            rob_clear_q <= 1'b0;
            clear_pc_q <= '0;
            st_commit_q <= 1'b0;
            st_tag_q <= '0;
        end else if (rdy_in) begin
            head_q <= head_d;
            tail_q <= tail_d;
            count_q <= count_d;
            busy_q <= busy_d;
            ready_q <= ready_d;
            is_br_q <= is_br_d;
            is_st_q <= is_st_d;
            rd_q <= rd_d;
            val_q <= val_d;
            npc_q <= npc_d;
            pred_q <= pred_d;
            clear_pending_q <= clear_pending_d;
            set_idx_q <= set_idx_d;
            set_val_q <= set_val_d;
            set_rec_q <= set_rec_d;
            rob_clear_q <= rob_clear_d;
            clear_pc_q <= clear_pc_d;
            st_commit_q <= st_commit_d;
            st_tag_q <= st_tag_d;
        end
    end

    assign rob_set_idx = set_idx_q;
    assign rob_set_reg_val = set_val_q;
    assign rob_set_recorder = set_rec_q;
    assign rob_clear = rob_clear_q;
    assign clear_pc = clear_pc_q;
    assign store_commit = st_commit_q;
    assign store_tag = st_tag_q;
endmodule

// File: tb/tb_reorder_buffer.sv
// Scoreboard bench for reorder_buffer: expected commits are queued at issue
// and popped by a commit monitor; scenario tasks check timing inline.
module tb_reorder_buffer;
    logic        clk_in, rst_in, rdy_in;
    logic        issue_valid, issue_is_br, issue_is_store;
    logic [4:0]  issue_rd;
    logic [31:0] issue_pred_pc;
    logic [3:0]  issue_tag;
    logic        rob_full;
    logic        wb1_valid, wb2_valid;
    logic [3:0]  wb1_tag, wb2_tag;
    logic [31:0] wb1_val, wb1_next_pc, wb2_val;
    logic [3:0]  qry1_tag, qry2_tag;
    logic        qry1_ready, qry2_ready;
    logic [31:0] qry1_val, qry2_val;
    logic [4:0]  rob_set_idx;
    logic [31:0] rob_set_reg_val;
    logic [3:0]  rob_set_recorder;
    logic        rob_clear;
    logic [31:0] clear_pc;
    logic        store_commit;
    logic [3:0]  store_tag;

    typedef struct {
        logic [4:0]  idx;
        logic [31:0] val;
        logic [3:0]  tag;
        logic        st;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    logic fire;

    reorder_buffer #(.ROB_SIZE_BIT(4)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .issue_is_br(issue_is_br), .issue_is_store(issue_is_store),
        .issue_pred_pc(issue_pred_pc), .issue_tag(issue_tag),
        .rob_full(rob_full),
        .wb1_valid(wb1_valid), .wb1_tag(wb1_tag), .wb1_val(wb1_val),
        .wb1_next_pc(wb1_next_pc),
        .wb2_valid(wb2_valid), .wb2_tag(wb2_tag), .wb2_val(wb2_val),
        .qry1_tag(qry1_tag), .qry2_tag(qry2_tag),
        .qry1_ready(qry1_ready), .qry2_ready(qry2_ready),
        .qry1_val(qry1_val), .qry2_val(qry2_val),
        .rob_set_idx(rob_set_idx), .rob_set_reg_val(rob_set_reg_val),
        .rob_set_recorder(rob_set_recorder), .rob_clear(rob_clear),
        .clear_pc(clear_pc), .store_commit(store_commit),
        .store_tag(store_tag)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // Marks negedges that follow an edge where state was allowed to advance.
    always @(posedge clk_in or posedge rst_in) begin
        if (rst_in) fire <= 1'b0;
        else fire <= rdy_in;
    end

    always @(negedge clk_in) begin
        if (fire && (rob_set_idx != 5'd0 || store_commit)) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL commit_unexpected idx=%0d val=%h rec=%0d",
                         rob_set_idx, rob_set_reg_val, rob_set_recorder);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (rob_set_idx !== e.idx || rob_set_reg_val !== e.val ||
                    rob_set_recorder !== e.tag || store_commit !== e.st ||
                    (e.st && store_tag !== e.tag)) begin
                    errors++;
                    $display("FAIL commit got idx=%0d val=%h rec=%0d st=%b stag=%0d exp idx=%0d val=%h tag=%0d st=%b",
                             rob_set_idx, rob_set_reg_val, rob_set_recorder,
                             store_commit, store_tag, e.idx, e.val, e.tag, e.st);
                end
            end
        end
    end

    task automatic idle();
        issue_valid = 0; issue_rd = 0; issue_is_br = 0;
        issue_is_store = 0; issue_pred_pc = 0;
        wb1_valid = 0; wb1_tag = 0; wb1_val = 0; wb1_next_pc = 0;
        wb2_valid = 0; wb2_tag = 0; wb2_val = 0;
    endtask

    task automatic apply_reset();
        idle();
        rdy_in = 1;
        rst_in = 1;
        @(negedge clk_in);
        @(negedge clk_in);
        exp_q.delete();
        rst_in = 0;
    endtask

    task automatic test_reset();
        idle();
        rdy_in = 1; qry1_tag = 0; qry2_tag = 0;
        rst_in = 1;
        #1;
        checks++;
        if (rob_full !== 0 || rob_set_idx !== 0 || rob_clear !== 0 ||
            store_commit !== 0 || clear_pc !== 0 || issue_tag !== 0 ||
            qry1_ready !== 0 || rob_set_reg_val !== 0) begin
            errors++;
            $display("FAIL reset full=%b idx=%0d clr=%b st=%b pc=%h tag=%0d q=%b",
                     rob_full, rob_set_idx, rob_clear, store_commit,
                     clear_pc, issue_tag, qry1_ready);
        end
        @(negedge clk_in);
        rst_in = 0;
    endtask

    task automatic test_basic();
        apply_reset();
        issue_valid = 1; issue_rd = 5;
        exp_q.push_back('{5'd5, 32'h1234, 4'd0, 1'b0});
        #1 checks++;
        if (issue_tag !== 0 || rob_full !== 0) begin
            errors++;
            $display("FAIL basic_alloc tag=%0d full=%b exp 0 0", issue_tag, rob_full);
        end
        @(negedge clk_in);
        idle();
        wb1_valid = 1; wb1_tag = 0; wb1_val = 32'h1234; wb1_next_pc = 32'h4;
        @(negedge clk_in);
        idle();
        qry1_tag = 0;
        #1 checks++;
        if (qry1_ready !== 1 || qry1_val !== 32'h1234 || rob_set_idx !== 0) begin
            errors++;
            $display("FAIL basic_qry rdy=%b val=%h idx=%0d exp 1 1234 0",
                     qry1_ready, qry1_val, rob_set_idx);
        end
        @(negedge clk_in);
        #1 checks++;
        if (rob_set_idx !== 5 || rob_set_reg_val !== 32'h1234) begin
            errors++;
            $display("FAIL basic_commit idx=%0d val=%h exp 5 1234",
                     rob_set_idx, rob_set_reg_val);
        end
        @(negedge clk_in);
        #1 checks++;
        if (rob_set_idx !== 0 || issue_tag !== 1) begin
            errors++;
            $display("FAIL basic_after idx=%0d tag=%0d exp 0 1", rob_set_idx, issue_tag);
        end
    endtask

    task automatic test_full();
        apply_reset();
        for (int i = 0; i < 16; i++) begin
            if (i > 0) @(negedge clk_in);
            issue_valid = 1; issue_rd = 5'(i + 1);
            if (i == 0) exp_q.push_back('{5'd1, 32'hA0, 4'd0, 1'b0});
            #1 checks++;
            if (issue_tag !== 4'(i) || rob_full !== 0) begin
                errors++;
                $display("FAIL full_fill i=%0d tag=%0d full=%b", i, issue_tag, rob_full);
            end
        end
        @(negedge clk_in);
        issue_rd = 5'd31;
        #1 checks++;
        if (rob_full !== 1 || issue_tag !== 0) begin
            errors++;
            $display("FAIL full_set full=%b tag=%0d exp 1 0", rob_full, issue_tag);
        end
        @(negedge clk_in);
        idle();
        wb1_valid = 1; wb1_tag = 0; wb1_val = 32'hA0; wb1_next_pc = 32'h4;
        #1 checks++;
        if (rob_full !== 1 || issue_tag !== 0) begin
            errors++;
            $display("FAIL full_ignored full=%b tag=%0d exp 1 0", rob_full, issue_tag);
        end
        @(negedge clk_in);
        idle();
        @(negedge clk_in);
        #1 checks++;
        if (rob_full !== 0 || rob_set_idx !== 1) begin
            errors++;
            $display("FAIL full_release full=%b idx=%0d exp 0 1", rob_full, rob_set_idx);
        end
    endtask

    task automatic test_out_of_order();
        logic [4:0] seq [4];
        seq = '{5'd1, 5'd2, 5'd3, 5'd0};
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk_in);
            issue_valid = 1; issue_rd = 5'(i + 1);
        end
        exp_q.push_back('{5'd1, 32'h10, 4'd0, 1'b0});
        exp_q.push_back('{5'd2, 32'h11, 4'd1, 1'b0});
        exp_q.push_back('{5'd3, 32'h22, 4'd2, 1'b0});
        @(negedge clk_in);
        idle();
        wb1_valid = 1; wb1_tag = 2; wb1_val = 32'h22; wb1_next_pc = 32'h4;
        @(negedge clk_in);
        idle();
        wb2_valid = 1; wb2_tag = 1; wb2_val = 32'h11;
        @(negedge clk_in);
        idle();
        wb1_valid = 1; wb1_tag = 0; wb1_val = 32'h10; wb1_next_pc = 32'h4;
        #1 checks++;
        if (rob_set_idx !== 0) begin
            errors++;
            $display("FAIL ooo_early idx=%0d exp 0", rob_set_idx);
        end
        @(negedge clk_in);
        idle();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk_in);
            #1 checks++;
            if (rob_set_idx !== seq[k]) begin
                errors++;
                $display("FAIL ooo_order k=%0d idx=%0d exp %0d", k, rob_set_idx, seq[k]);
            end
        end
    endtask

    task automatic test_mispredict();
        apply_reset();
        issue_valid = 1; issue_rd = 1; issue_is_br = 1; issue_pred_pc = 32'h100;
        exp_q.push_back('{5'd1, 32'h8, 4'd0, 1'b0});
        @(negedge clk_in);
        idle();
        issue_valid = 1; issue_rd = 2;
        @(negedge clk_in);
        idle();
        wb1_valid = 1; wb1_tag = 0; wb1_val = 32'h8; wb1_next_pc = 32'h200;
        wb2_valid = 1; wb2_tag = 1; wb2_val = 32'h99;
        @(negedge clk_in);
        idle();
        @(negedge clk_in);
        issue_valid = 1; issue_rd = 7;
        #1 checks++;
        if (rob_set_idx !== 1 || rob_set_reg_val !== 8 || rob_full !== 1 || rob_clear !== 0) begin
            errors++;
            $display("FAIL mp_write idx=%0d val=%h full=%b clr=%b exp 1 8 1 0",
                     rob_set_idx, rob_set_reg_val, rob_full, rob_clear);
        end
        @(negedge clk_in);
        #1 checks++;
        if (rob_clear !== 1 || clear_pc !== 32'h200 || rob_full !== 1 || rob_set_idx !== 0) begin
            errors++;
            $display("FAIL mp_clear clr=%b pc=%h full=%b idx=%0d exp 1 200 1 0",
                     rob_clear, clear_pc, rob_full, rob_set_idx);
        end
        @(negedge clk_in);
        idle();
        #1 checks++;
        if (rob_clear !== 0 || rob_full !== 0 || issue_tag !== 0) begin
            errors++;
            $display("FAIL mp_after clr=%b full=%b tag=%0d exp 0 0 0",
                     rob_clear, rob_full, issue_tag);
        end
    endtask

    task automatic test_store_bypass();
        logic [31:0] vals [4];
        int n;
        logic found;
        vals = '{32'h40, 32'h50, 32'h60, 32'hABC};
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk_in);
            issue_valid = 1;
            issue_rd = (i == 3) ? 5'd0 : 5'(i + 4);
            issue_is_store = (i == 3);
        end
        exp_q.push_back('{5'd4, 32'h40, 4'd0, 1'b0});
        exp_q.push_back('{5'd5, 32'h50, 4'd1, 1'b0});
        exp_q.push_back('{5'd6, 32'h60, 4'd2, 1'b0});
        exp_q.push_back('{5'd0, 32'hABC, 4'd3, 1'b1});
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_in);
            idle();
            wb2_valid = 1; wb2_tag = 4'(i); wb2_val = vals[i];
        end
        @(negedge clk_in);
        idle();
        n = 0; found = 0;
        while (!found && n < 12) begin
            @(negedge clk_in);
            #1;
            if (store_commit) found = 1;
            n++;
        end
        checks++;
        if (!found || store_tag !== 3 || rob_set_idx !== 0) begin
            errors++;
            $display("FAIL store_commit seen=%b stag=%0d idx=%0d exp 1 3 0",
                     found, store_tag, rob_set_idx);
        end
        @(negedge clk_in);
        qry1_tag = 7; wb1_valid = 1; wb1_tag = 7; wb1_val = 32'h77; wb1_next_pc = 32'h4;
        qry2_tag = 6; wb2_valid = 1; wb2_tag = 6; wb2_val = 32'h66;
        #1 checks++;
        if (store_commit !== 0) begin
            errors++;
            $display("FAIL store_pulse st=%b exp 0", store_commit);
        end
        checks++;
        if (qry1_ready !== 1 || qry1_val !== 32'h77 || qry2_ready !== 1 || qry2_val !== 32'h66) begin
            errors++;
            $display("FAIL bypass q1=%b %h q2=%b %h exp 1 77 1 66",
                     qry1_ready, qry1_val, qry2_ready, qry2_val);
        end
        @(negedge clk_in);
        idle();
        #1 checks++;
        if (qry1_ready !== 0 || qry2_ready !== 0) begin
            errors++;
            $display("FAIL wb_unalloc q1=%b q2=%b exp 0 0", qry1_ready, qry2_ready);
        end
    endtask

    task automatic test_rdy_and_async_reset();
        apply_reset();
        issue_valid = 1; issue_rd = 9;
        exp_q.push_back('{5'd9, 32'h900, 4'd0, 1'b0});
        @(negedge clk_in);
        issue_rd = 10;
        exp_q.push_back('{5'd10, 32'hA00, 4'd1, 1'b0});
        @(negedge clk_in);
        idle();
        wb1_valid = 1; wb1_tag = 0; wb1_val = 32'h900; wb1_next_pc = 32'h4;
        wb2_valid = 1; wb2_tag = 1; wb2_val = 32'hA00;
        @(negedge clk_in);
        idle();
        rdy_in = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_in);
            #1 checks++;
            if (rob_set_idx !== 0) begin
                errors++;
                $display("FAIL rdy_nocommit k=%0d idx=%0d exp 0", k, rob_set_idx);
            end
        end
        rdy_in = 1;
        @(negedge clk_in);
        rdy_in = 0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk_in);
            #1 checks++;
            if (rob_set_idx !== 9 || rob_set_reg_val !== 32'h900 || rob_set_recorder !== 0) begin
                errors++;
                $display("FAIL rdy_hold k=%0d idx=%0d val=%h rec=%0d exp 9 900 0",
                         k, rob_set_idx, rob_set_reg_val, rob_set_recorder);
            end
        end
        rdy_in = 1;
        @(negedge clk_in);
        #1 checks++;
        if (rob_set_idx !== 10) begin
            errors++;
            $display("FAIL rdy_resume idx=%0d exp 10", rob_set_idx);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_left n=%0d exp 0", exp_q.size());
        end
        issue_valid = 1; issue_rd = 3;
        #1 rst_in = 1;
        #1 checks++;
        if (rob_set_idx !== 0 || rob_set_reg_val !== 0 || rob_set_recorder !== 0 ||
            rob_full !== 0 || issue_tag !== 0 || store_tag !== 0) begin
            errors++;
            $display("FAIL async_reset idx=%0d val=%h rec=%0d full=%b tag=%0d exp all 0",
                     rob_set_idx, rob_set_reg_val, rob_set_recorder, rob_full, issue_tag);
        end
        idle();
        exp_q.delete();
        @(negedge clk_in);
        rst_in = 0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full();
        test_out_of_order();
        test_mispredict();
        test_store_bypass();
        test_rdy_and_async_reset();
        repeat (2) @(negedge clk_in);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
